// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Start/Ready handshake, operands and results of the sequential divider.
interface divisor_secuencial_if #(
  parameter int unsigned W = div_pkg::W_DEF
);
  logic         Start;
  logic [W-1:0] Dividendo;
  logic [W-1:0] Divisor;
  logic [W-1:0] Cociente;
  logic [W-1:0] Residuo;
  logic         Ready;
  logic         DivCero;

  modport master (
    output Start, Dividendo, Divisor,
    input  Cociente, Residuo, Ready, DivCero
  );

  modport slave (
    input  Start, Dividendo, Divisor,
    output Cociente, Residuo, Ready, DivCero
  );
endinterface

// File: rtl/div_paso.sv
// One restoring division step: shift in the next dividend bit, trial-subtract D.
module div_paso #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   r,
  input  logic         q_msb,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic         q_bit
);
  logic [W:0] t;
  logic [W:0] d_ext;
  logic       unused_r_msb;

  // Partial remainder stays below D, so its top bit never reaches the shift.
  assign unused_r_msb = r[W];
  assign t            = {r[W-1:0], q_msb};
  assign d_ext        = {1'b0, d};
  assign q_bit        = (t >= d_ext);
  assign r_next       = q_bit ? (t - d_ext) : t;
endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring unsigned divider, one quotient bit per clock, Start/Ready handshake.
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic Clock,
  input  logic Reset,
  divisor_secuencial_if.slave bus
);
  localparam int unsigned   CW       = cnt_w(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [W:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  cociente_q, cociente_d;
  logic [W-1:0]  residuo_q, residuo_d;
  logic          ready_q, ready_d;
  logic          divcero_q, divcero_d;

  logic [W:0]    r_nxt;
  logic          q_bit;

  div_paso #(.W(W)) u_paso (
    .r      (r_q),
    .q_msb  (q_q[W-1]),
    .d      (d_q),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      ready_q    <= 1'b0;
      divcero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      d_q        <= d_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      ready_q    <= ready_d;
      divcero_q  <= divcero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    d_d        = d_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    ready_d    = ready_q;
    divcero_d  = divcero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          q_d     = bus.Dividendo;
          d_d     = bus.Divisor;
          r_d     = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor resolves on the first CALC edge with the saturated result.
        if (d_q == '0) begin
          cociente_d = '1;
          residuo_d  = q_q;
          divcero_d  = 1'b1;
          ready_d    = 1'b1;
          state_d    = DONE;
        end else begin
          r_d = r_nxt;
          q_d = {q_q[W-2:0], q_bit};
          if (cnt_q == CNT_LAST) begin
            cociente_d = {q_q[W-2:0], q_bit};
            residuo_d  = r_nxt[W-1:0];
            divcero_d  = 1'b0;
            ready_d    = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Cociente = cociente_q;
  assign bus.Residuo  = residuo_q;
  assign bus.Ready    = ready_q;
  assign bus.DivCero  = divcero_q;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed and random checks of divisor_secuencial against an arithmetic reference.
module tb_divisor_secuencial;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] last_c;
  logic [7:0] last_r;

  divisor_secuencial_if #(.W(8)) bus ();

  divisor_secuencial #(.W(8)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // inject: CALC cycle at which a spurious Start is pulsed (0 = none).
  // hold: keep Start asserted until Ready returns (back-to-back from DONE).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inject, input bit hold);
    logic [7:0] ec, er;
    logic       ez;
    int         lat;
    int         n;
    if (b == 8'd0) begin
      ec = 8'hFF; er = a; ez = 1'b1; lat = 1;
    end else begin
      ec = a / b; er = a % b; ez = 1'b0; lat = 8;
    end
    @(negedge clk);
    bus.Start = 1'b1; bus.Dividendo = a; bus.Divisor = b;
    @(posedge clk); #1;
    check("ready_fall", 8'(bus.Ready), 8'd0);
    if (!hold) bus.Start = 1'b0;
    bus.Dividendo = 8'($urandom);
    bus.Divisor   = 8'($urandom);
    n = 0;
    while (bus.Ready !== 1'b1 && n < 20) begin
      check("hold_coc", bus.Cociente, last_c);
      check("hold_res", bus.Residuo, last_r);
      if (inject != 0 && n == inject) begin
        bus.Start = 1'b1; bus.Dividendo = 8'($urandom); bus.Divisor = 8'($urandom_range(1, 255));
      end else if (!hold) begin
        bus.Start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.Start = 1'b0;
    check("latency", 8'(n), 8'(lat));
    check("cociente", bus.Cociente, ec);
    check("residuo", bus.Residuo, er);
    check("divcero", 8'(bus.DivCero), 8'(ez));
    check("ready", 8'(bus.Ready), 8'd1);
    last_c = ec;
    last_r = er;
  endtask

  initial begin
    logic [7:0] a, b;
    checks = 0; errors = 0;
    last_c = 8'd0; last_r = 8'd0;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Dividendo = 8'd0; bus.Divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coc", bus.Cociente, 8'd0);
    check("rst_res", bus.Residuo, 8'd0);
    check("rst_ready", 8'(bus.Ready), 8'd0);
    check("rst_divcero", 8'(bus.DivCero), 8'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 8'(bus.Ready), 8'd0);

    run_op(8'd223, 8'd15, 0, 1'b0);
    run_op(8'd215, 8'd223, 0, 1'b0);
    run_op(8'd255, 8'd1, 0, 1'b0);
    run_op(8'd100, 8'd0, 0, 1'b0);
    run_op(8'd37, 8'd5, 3, 1'b0);
    run_op(8'd200, 8'd7, 0, 1'b1);
    run_op(8'd0, 8'd9, 0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      if (i % 6 == 0) b = 8'd0;
      else if (i % 4 == 1) b = 8'($urandom_range(1, 15));
      else b = 8'($urandom_range(1, 255));
      run_op(a, b, (i % 5 == 2) ? 2 + (i % 5) : 0, (i % 7 == 3));
    end

    // Abort in the middle of CALC.
    @(negedge clk);
    bus.Start = 1'b1; bus.Dividendo = 8'd223; bus.Divisor = 8'd15;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_coc", bus.Cociente, 8'd0);
    check("abort_res", bus.Residuo, 8'd0);
    check("abort_ready", 8'(bus.Ready), 8'd0);
    check("abort_divcero", 8'(bus.DivCero), 8'd0);
    last_c = 8'd0; last_r = 8'd0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_abort_ready", 8'(bus.Ready), 8'd0);
    check("post_abort_coc", bus.Cociente, 8'd0);
    run_op(8'd223, 8'd15, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
